// File: rtl/ram_dual_port.sv
// True dual-port synchronous RAM with byte enables, selectable write-cycle read mode,
// optional output register, per-port read-valid and same-address collision flag.
module ram_dual_port #(
  parameter int    DATA_WIDTH = 32,
  parameter int    ADDR_WIDTH = 10,
  parameter int    DATA_DEPTH = 1024,
  parameter string MODE       = "READ_FIRST",
  parameter int    OUT_REG    = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    a_en,
  input  logic                    a_wrn,
  input  logic [DATA_WIDTH/8-1:0] a_be,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [DATA_WIDTH-1:0]   a_din,
  output logic [DATA_WIDTH-1:0]   a_dout,
  output logic                    a_valid,
  input  logic                    b_en,
  input  logic                    b_wrn,
  input  logic [DATA_WIDTH/8-1:0] b_be,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  input  logic [DATA_WIDTH-1:0]   b_din,
  output logic [DATA_WIDTH-1:0]   b_dout,
  output logic                    b_valid,
  output logic                    coll
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DATA_DEPTH);
  localparam bit MODE_WF = (MODE == "WRITE_FIRST");
  localparam bit MODE_NC = (MODE == "NO_CHANGE");

  logic [DATA_WIDTH-1:0] r_mem [DATA_DEPTH];

  function automatic logic [DATA_WIDTH-1:0] byte_merge(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [NB-1:0]         be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < NB; i++)
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    return res;
  endfunction

  // Returns {valid, data} for the first stage; hold is the currently registered data.
  function automatic logic [DATA_WIDTH:0] next_rd(
    input logic                  en,
    input logic                  wrn,
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] din,
    input logic [NB-1:0]         be,
    input logic [DATA_WIDTH-1:0] hold
  );
    if (!en)
      return {1'b0, hold};
    if (!wrn)
      return {1'b1, old_w};
    if (MODE_NC)
      return {1'b0, hold};
    if (MODE_WF)
      return {1'b1, byte_merge(old_w, din, be)};
    return {1'b1, old_w};
  endfunction

  logic                  w_a_inr, w_b_inr;
  logic                  w_a_we, w_b_we;
  logic                  w_same;
  logic                  w_coll;
  logic [NB-1:0]         w_b_mask;
  logic [DATA_WIDTH-1:0] w_a_old, w_b_old;
  logic [DATA_WIDTH:0]   w_a_nxt, w_b_nxt;

  assign w_a_inr  = ({1'b0, a_addr} < DEPTH_L);
  assign w_b_inr  = ({1'b0, b_addr} < DEPTH_L);
  assign w_a_we   = a_en && a_wrn && w_a_inr;
  assign w_b_we   = b_en && b_wrn && w_b_inr;
  assign w_same   = a_en && b_en && w_a_inr && w_b_inr && (a_addr == b_addr);
  assign w_coll   = w_same && (a_wrn || b_wrn);
  // Port A owns every byte it enables when both ports write the same word.
  assign w_b_mask = (w_same && w_a_we) ? (b_be & ~a_be) : b_be;

  // Array read happens before the edge, so a reader colliding with a writer sees the old word.
  assign w_a_old  = w_a_inr ? r_mem[a_addr] : '0;
  assign w_b_old  = w_b_inr ? r_mem[b_addr] : '0;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NB; i++) begin
        if (w_a_we && a_be[i])     r_mem[a_addr][8*i +: 8] <= a_din[8*i +: 8];
        if (w_b_we && w_b_mask[i]) r_mem[b_addr][8*i +: 8] <= b_din[8*i +: 8];
      end
    end
  end

  logic [DATA_WIDTH-1:0] r_a_dout_p1, r_b_dout_p1;
  logic                  r_a_vld_p1, r_b_vld_p1, r_coll_p1;

  assign w_a_nxt = next_rd(a_en, a_wrn, w_a_old, a_din, a_be, r_a_dout_p1);
  assign w_b_nxt = next_rd(b_en, b_wrn, w_b_old, b_din, b_be, r_b_dout_p1);

  // Stage p1: array read / write-cycle data selection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_dout_p1 <= '0;
      r_b_dout_p1 <= '0;
      r_a_vld_p1  <= 1'b0;
      r_b_vld_p1  <= 1'b0;
      r_coll_p1   <= 1'b0;
    end else begin
      r_a_dout_p1 <= w_a_nxt[DATA_WIDTH-1:0];
      r_b_dout_p1 <= w_b_nxt[DATA_WIDTH-1:0];
      r_a_vld_p1  <= w_a_nxt[DATA_WIDTH];
      r_b_vld_p1  <= w_b_nxt[DATA_WIDTH];
      r_coll_p1   <= w_coll;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] r_a_dout_p2, r_b_dout_p2;
      logic                  r_a_vld_p2, r_b_vld_p2, r_coll_p2;

      // Stage p2: optional output register, free-running
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a_dout_p2 <= '0;
          r_b_dout_p2 <= '0;
          r_a_vld_p2  <= 1'b0;
          r_b_vld_p2  <= 1'b0;
          r_coll_p2   <= 1'b0;
        end else begin
          r_a_dout_p2 <= r_a_dout_p1;
          r_b_dout_p2 <= r_b_dout_p1;
          r_a_vld_p2  <= r_a_vld_p1;
          r_b_vld_p2  <= r_b_vld_p1;
          r_coll_p2   <= r_coll_p1;
        end
      end

      assign a_dout  = r_a_dout_p2;
      assign b_dout  = r_b_dout_p2;
      assign a_valid = r_a_vld_p2;
      assign b_valid = r_b_vld_p2;
      assign coll    = r_coll_p2;
    end else begin : g_noreg
      assign a_dout  = r_a_dout_p1;
      assign b_dout  = r_b_dout_p1;
      assign a_valid = r_a_vld_p1;
      assign b_valid = r_b_vld_p1;
      assign coll    = r_coll_p1;
    end
  endgenerate

endmodule

// File: tb/tb_ram_dual_port.sv
// Directed bench: three RAM instances (READ_FIRST/lat1, WRITE_FIRST/lat2, NO_CHANGE/lat1)
// driven by one shared stimulus, with hand-computed expected values.
module tb_ram_dual_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_en, a_wrn, b_en, b_wrn;
  logic [3:0]  a_be, b_be;
  logic [9:0]  a_addr, b_addr;
  logic [31:0] a_din, b_din;

  logic [31:0] d0_adout, d0_bdout, d1_adout, d1_bdout, d2_adout, d2_bdout;
  logic        d0_avld, d0_bvld, d0_coll;
  logic        d1_avld, d1_bvld, d1_coll;
  logic        d2_avld, d2_bvld, d2_coll;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_dual_port #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .DATA_DEPTH(1000),
                  .MODE("READ_FIRST"), .OUT_REG(0)) u_d0 (
    .clk(clk), .rst_n(rst_n),
    .a_en(a_en), .a_wrn(a_wrn), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
    .a_dout(d0_adout), .a_valid(d0_avld),
    .b_en(b_en), .b_wrn(b_wrn), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
    .b_dout(d0_bdout), .b_valid(d0_bvld), .coll(d0_coll));

  ram_dual_port #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .DATA_DEPTH(1000),
                  .MODE("WRITE_FIRST"), .OUT_REG(1)) u_d1 (
    .clk(clk), .rst_n(rst_n),
    .a_en(a_en), .a_wrn(a_wrn), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
    .a_dout(d1_adout), .a_valid(d1_avld),
    .b_en(b_en), .b_wrn(b_wrn), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
    .b_dout(d1_bdout), .b_valid(d1_bvld), .coll(d1_coll));

  ram_dual_port #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .DATA_DEPTH(1000),
                  .MODE("NO_CHANGE"), .OUT_REG(0)) u_d2 (
    .clk(clk), .rst_n(rst_n),
    .a_en(a_en), .a_wrn(a_wrn), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
    .a_dout(d2_adout), .a_valid(d2_avld),
    .b_en(b_en), .b_wrn(b_wrn), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
    .b_dout(d2_bdout), .b_valid(d2_bvld), .coll(d2_coll));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv_a(input logic wrn, input logic [3:0] be, input logic [9:0] addr,
                       input logic [31:0] din);
    a_en = 1'b1; a_wrn = wrn; a_be = be; a_addr = addr; a_din = din;
  endtask

  task automatic drv_b(input logic wrn, input logic [3:0] be, input logic [9:0] addr,
                       input logic [31:0] din);
    b_en = 1'b1; b_wrn = wrn; b_be = be; b_addr = addr; b_din = din;
  endtask

  task automatic go();
    @(posedge clk);
    #1;
    a_en = 1'b0;
    b_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] sq;
    rst_n = 1'b0;
    a_en = 1'b0; a_wrn = 1'b0; a_be = '0; a_addr = '0; a_din = '0;
    b_en = 1'b0; b_wrn = 1'b0; b_be = '0; b_addr = '0; b_din = '0;
    @(posedge clk); @(posedge clk); #1;

    chk("rst_d0_adout", d0_adout, 32'h0);
    chk("rst_d0_avld",  {31'b0, d0_avld}, 32'h0);
    chk("rst_d0_bvld",  {31'b0, d0_bvld}, 32'h0);
    chk("rst_d0_coll",  {31'b0, d0_coll}, 32'h0);
    chk("rst_d1_adout", d1_adout, 32'h0);
    chk("rst_d1_avld",  {31'b0, d1_avld}, 32'h0);
    chk("rst_d2_bdout", d2_bdout, 32'h0);
    rst_n = 1'b1;

    // fill 0..9 with i*i
    for (int i = 0; i < 10; i++) begin
      sq = 32'(i * i);
      drv_a(1'b1, 4'hF, 10'(i), sq);
      go();
    end
    go();

    // readback
    for (int i = 0; i < 10; i++) begin
      sq = 32'(i * i);
      drv_a(1'b0, 4'hF, 10'(i), 32'h0);
      go();
      chk("rd_d0_dout", d0_adout, sq);
      chk("rd_d0_vld",  {31'b0, d0_avld}, 32'h1);
      chk("rd_d2_dout", d2_adout, sq);
      go();
      chk("rd_d1_dout", d1_adout, sq);
      chk("rd_d1_vld",  {31'b0, d1_avld}, 32'h1);
      chk("idle_d0_vld", {31'b0, d0_avld}, 32'h0);
      chk("idle_d0_hold", d0_adout, sq);
    end

    // byte enables
    drv_a(1'b1, 4'hF, 10'd5, 32'hFFFF_FFFF);
    go();
    drv_a(1'b1, 4'b0101, 10'd5, 32'h1234_5678);
    go();
    chk("be_d0_rf_old",  d0_adout, 32'hFFFF_FFFF);
    chk("be_d2_nc_hold", d2_adout, 32'h0000_0051);
    chk("be_d2_nc_vld",  {31'b0, d2_avld}, 32'h0);
    go();
    chk("be_d1_wf_new",  d1_adout, 32'hFF34_FF78);
    drv_a(1'b0, 4'hF, 10'd5, 32'h0);
    go();
    chk("be_d0_rd", d0_adout, 32'hFF34_FF78);
    chk("be_d2_rd", d2_adout, 32'hFF34_FF78);
    go();
    chk("be_d1_rd", d1_adout, 32'hFF34_FF78);

    // write-cycle read mode
    drv_a(1'b1, 4'hF, 10'd3, 32'hAAAA_AAAA);
    go(); go();
    drv_a(1'b1, 4'hF, 10'd3, 32'h5555_5555);
    go();
    chk("mode_rf_dout", d0_adout, 32'hAAAA_AAAA);
    chk("mode_rf_vld",  {31'b0, d0_avld}, 32'h1);
    chk("mode_nc_dout", d2_adout, 32'hFF34_FF78);
    chk("mode_nc_vld",  {31'b0, d2_avld}, 32'h0);
    go();
    chk("mode_wf_dout", d1_adout, 32'h5555_5555);
    chk("mode_wf_vld",  {31'b0, d1_avld}, 32'h1);
    drv_a(1'b0, 4'hF, 10'd3, 32'h0);
    go();
    chk("mode_rd_d0", d0_adout, 32'h5555_5555);

    // write/write collision
    drv_a(1'b1, 4'b0011, 10'd7, 32'h1111_1111);
    drv_b(1'b1, 4'b1111, 10'd7, 32'h2222_2222);
    go();
    chk("ww_d0_coll", {31'b0, d0_coll}, 32'h1);
    chk("ww_d2_coll", {31'b0, d2_coll}, 32'h1);
    go();
    chk("ww_d1_coll", {31'b0, d1_coll}, 32'h1);
    chk("ww_d0_coll_clr", {31'b0, d0_coll}, 32'h0);
    drv_a(1'b0, 4'hF, 10'd7, 32'h0);
    go();
    chk("ww_d0_mem", d0_adout, 32'h2222_1111);
    chk("ww_d2_mem", d2_adout, 32'h2222_1111);
    go();
    chk("ww_d1_mem", d1_adout, 32'h2222_1111);

    // write/read collision: reader sees old word in every mode
    drv_a(1'b1, 4'hF, 10'd7, 32'hCAFE_F00D);
    drv_b(1'b0, 4'hF, 10'd7, 32'h0);
    go();
    chk("wr_d0_bdout", d0_bdout, 32'h2222_1111);
    chk("wr_d0_bvld",  {31'b0, d0_bvld}, 32'h1);
    chk("wr_d0_coll",  {31'b0, d0_coll}, 32'h1);
    chk("wr_d0_adout", d0_adout, 32'h2222_1111);
    chk("wr_d2_bdout", d2_bdout, 32'h2222_1111);
    go();
    chk("wr_d1_bdout", d1_bdout, 32'h2222_1111);
    chk("wr_d1_coll",  {31'b0, d1_coll}, 32'h1);
    chk("wr_d1_adout", d1_adout, 32'hCAFE_F00D);

    // out-of-range
    drv_a(1'b1, 4'hF, 10'd1000, 32'hDEAD_BEEF);
    drv_b(1'b0, 4'hF, 10'd1000, 32'h0);
    go();
    chk("oor_d0_coll",  {31'b0, d0_coll}, 32'h0);
    chk("oor_d0_bdout", d0_bdout, 32'h0);
    chk("oor_d0_bvld",  {31'b0, d0_bvld}, 32'h1);
    go();
    chk("oor_d1_coll",  {31'b0, d1_coll}, 32'h0);
    chk("oor_d1_bdout", d1_bdout, 32'h0);
    drv_a(1'b0, 4'hF, 10'd1000, 32'h0);
    go();
    chk("oor_d0_adout", d0_adout, 32'h0);
    chk("oor_d0_avld",  {31'b0, d0_avld}, 32'h1);

    // asynchronous reset in the middle of a read burst
    drv_a(1'b0, 4'hF, 10'd2, 32'h0);
    go();
    chk("burst_d0", d0_adout, 32'h4);
    drv_a(1'b0, 4'hF, 10'd3, 32'h0);
    drv_b(1'b1, 4'hF, 10'd3, 32'h7777_7777);
    @(posedge clk); #1;
    drv_a(1'b0, 4'hF, 10'd9, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_d0_adout", d0_adout, 32'h0);
    chk("arst_d0_avld",  {31'b0, d0_avld}, 32'h0);
    chk("arst_d0_coll",  {31'b0, d0_coll}, 32'h0);
    chk("arst_d1_adout", d1_adout, 32'h0);
    chk("arst_d1_coll",  {31'b0, d1_coll}, 32'h0);
    drv_a(1'b1, 4'hF, 10'd2, 32'hBADB_AD00);
    b_en = 1'b0;
    @(posedge clk); #1;
    chk("arst_hold_d0", d0_adout, 32'h0);
    a_en = 1'b0;
    #2;
    rst_n = 1'b1;
    drv_a(1'b0, 4'hF, 10'd2, 32'h0);
    go();
    chk("post_rst_d0_addr2", d0_adout, 32'h4);
    chk("post_rst_d2_addr2", d2_adout, 32'h4);
    go();
    chk("post_rst_d1_addr2", d1_adout, 32'h4);
    drv_a(1'b0, 4'hF, 10'd3, 32'h0);
    go();
    chk("post_rst_d0_addr3", d0_adout, 32'h7777_7777);
    drv_a(1'b0, 4'hF, 10'd9, 32'h0);
    go();
    chk("post_rst_d0_addr9", d0_adout, 32'h51);
    chk("post_rst_d0_vld",   {31'b0, d0_avld}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
